// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and polarity-correct N async inputs,
// producing clean levels, registered rise/fall pulses and sticky press flags.
module input_conditioner #(
    parameter int              N_CH            = 8,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 1_500_000,
    parameter logic [N_CH-1:0] INVERT          = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sig_i,
    input  logic [N_CH-1:0] clear_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] event_o,
    output logic            changed_o
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [N_CH-1:0] s, level_q, level_d, rise_q, rise_d, fall_q, fall_d, event_q, event_d;
    logic            changed_q, changed_d;

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    // Any sample matching the current level restarts the count.
    always_comb begin
        level_d = level_q;
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k] = (s[k] != level_q[k] && cnt_q[k] != CNT_MAX) ? cnt_q[k] + 1'b1 : '0;
            level_d[k] = (s[k] != level_q[k] && cnt_q[k] == CNT_MAX) ? s[k] : level_q[k];
        end
        rise_d    = level_d & ~level_q;
        fall_d    = ~level_d & level_q;
        event_d   = rise_d | (event_q & ~clear_i);
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
            level_q   <= INVERT;
            rise_q    <= '0;
            fall_q    <= '0;
            event_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q[0] <= sig_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            event_q   <= event_d;
            changed_q <= changed_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign event_o   = event_q;
    assign changed_o = changed_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random checks of input_conditioner against
// a sample-window reference model.
module tb_input_conditioner;
    localparam int         D   = 4;
    localparam logic [3:0] INV = 4'b0010;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sig, clear;
    logic [3:0] level_o, rise_o, fall_o, event_o;
    logic       changed_o;
    int         vectors = 0;
    int         miscompares = 0;

    // Model state: pin delay line, last D sampled levels per channel, outputs.
    logic [3:0]   m_d0, m_d1, m_lvl, m_rise, m_fall, m_ev;
    logic         m_ch;
    logic [D-1:0] m_win [4];

    input_conditioner #(
        .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .INVERT(INV)
    ) dut (
        .clk(clk), .reset(reset), .sig_i(sig), .clear_i(clear),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
        .event_o(event_o), .changed_o(changed_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last D synchronised samples all disagree with it.
    task automatic model_edge();
        logic [3:0] s, nl;
        if (reset) begin
            m_d0 = '0; m_d1 = '0; m_lvl = INV;
            m_rise = '0; m_fall = '0; m_ev = '0; m_ch = 1'b0;
            for (int k = 0; k < 4; k++) m_win[k] = {D{INV[k]}};
        end else begin
            s  = m_d1 ^ INV;
            nl = m_lvl;
            for (int k = 0; k < 4; k++) begin
                m_win[k] = {m_win[k][D-2:0], s[k]};
                if (m_win[k] == {D{~m_lvl[k]}}) nl[k] = ~m_lvl[k];
            end
            m_rise = nl & ~m_lvl;
            m_fall = ~nl & m_lvl;
            m_ev   = m_rise | (m_ev & ~clear);
            m_ch   = |(m_rise | m_fall);
            m_lvl  = nl;
            m_d1   = m_d0;
            m_d0   = sig;
        end
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            model_edge();
            @(posedge clk);
            #1;
            chk("level", level_o, m_lvl);
            chk("rise", rise_o, m_rise);
            chk("fall", fall_o, m_fall);
            chk("event", event_o, m_ev);
            chk("changed", {3'b0, changed_o}, {3'b0, m_ch});
        end
    endtask

    initial begin
        reset = 1'b1; sig = 4'b0000; clear = 4'b0000;
        step(3);
        reset = 1'b0;
        chk("rst_level", level_o, 4'b0010);
        chk("rst_pulses", rise_o | fall_o | event_o, 4'b0000);
        chk("rst_changed", {3'b0, changed_o}, 4'b0000);

        sig[0] = 1'b1;
        step(5);
        chk("press_early", {3'b0, level_o[0]}, 4'd0);
        step(1);
        chk("press_level", {3'b0, level_o[0]}, 4'd1);
        chk("press_rise", rise_o, 4'b0001);
        chk("press_changed", {3'b0, changed_o}, 4'd1);
        step(1);
        chk("press_rise_end", rise_o, 4'b0000);
        chk("press_event", {3'b0, event_o[0]}, 4'd1);

        sig[2] = 1'b1; step(3); sig[2] = 1'b0; step(8);
        chk("glitch_level", {3'b0, level_o[2]}, 4'd0);
        sig[2] = 1'b1; step(4); sig[2] = 1'b0; step(1);
        chk("accept_early", {3'b0, level_o[2]}, 4'd0);
        step(1);
        chk("accept_level", {3'b0, level_o[2]}, 4'd1);
        chk("accept_rise", rise_o, 4'b0100);
        step(10);

        sig[1] = 1'b1; step(6);
        chk("inv_release_fall", fall_o, 4'b0010);
        sig[1] = 1'b0; step(6);
        chk("inv_press_rise", rise_o, 4'b0010);
        chk("inv_press_level", {3'b0, level_o[1]}, 4'd1);
        sig[1] = 1'b1; step(6);
        chk("inv_fall", fall_o, 4'b0010);
        chk("inv_event_kept", {3'b0, event_o[1]}, 4'd1);

        sig[3] = 1'b1; step(5);
        clear[3] = 1'b1; step(1);
        chk("collide_rise", {3'b0, rise_o[3]}, 4'd1);
        chk("collide_event", {3'b0, event_o[3]}, 4'd1);
        step(1);
        chk("clear_event", {3'b0, event_o[3]}, 4'd0);
        clear = 4'b0000;

        sig = 4'b0000; step(12);
        chk("idle_level", level_o, 4'b0010);
        sig[0] = 1'b1; step(4);
        reset = 1'b1; sig = 4'b0000; step(1);
        reset = 1'b0;
        chk("abort_rise", rise_o, 4'b0000);
        chk("abort_level", level_o, 4'b0010);
        step(2);
        sig = 4'b1101; step(5);
        chk("multi_early", rise_o, 4'b0000);
        step(1);
        chk("multi_rise", rise_o, 4'b1101);
        chk("multi_changed", {3'b0, changed_o}, 4'd1);
        step(1);
        chk("multi_changed_end", {3'b0, changed_o}, 4'd0);

        for (int t = 0; t < 500; t++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) sig[k] = ~sig[k];
            clear = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
